// File: rtl/pattern_scan_controller.sv
// rtl/pattern_scan_controller.sv - word-to-serial sequencer around a Mealy pattern detector
// Scans each word MSB first, counts detector matches and keeps a saturating running total.
module pattern_scan_controller #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5,
   parameter int TOT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             det_rst,
   output logic             det_i,
   input  logic [1:0]       det_o,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             out_hit,
   output logic [CNT_W-1:0] out_first,
   output logic [TOT_W-1:0] total
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;
   localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({TOT_W{1'b1}});

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] idx;
   logic             match;
   logic             last_bit;
   logic [CNT_W-1:0] count_next;
   logic [SUM_W-1:0] total_sum;
   logic [TOT_W-1:0] total_sat;

   assign match      = (det_o == 2'b10);
   assign last_bit   = (idx == CNT_W'(WIDTH - 1));
   assign count_next = out_count + {{(CNT_W-1){1'b0}}, match};
   // The final bit's match must reach the total in the same edge that leaves SHIFT.
   assign total_sum  = SUM_W'(total) + SUM_W'(count_next);
   assign total_sat  = (total_sum > SAT_MAX) ? {TOT_W{1'b1}} : total_sum[TOT_W-1:0];

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = SHIFT;
         SHIFT:   if (last_bit)  state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      det_rst   = 1'b1;
      det_i     = 1'b0;
      case (state)
         IDLE:  in_ready = 1'b1;
         SHIFT: begin
            det_rst = 1'b0;
            det_i   = shreg[WIDTH-1];
         end
         DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shreg     <= '0;
         idx       <= '0;
         out_count <= '0;
         out_first <= '0;
         out_hit   <= 1'b0;
         total     <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               shreg     <= in_data;
               idx       <= '0;
               out_count <= '0;
               out_first <= '0;
               out_hit   <= 1'b0;
            end
            SHIFT: begin
               shreg     <= {shreg[WIDTH-2:0], 1'b0};
               idx       <= idx + CNT_W'(1);
               out_count <= count_next;
               if (match && !out_hit) begin
                  out_first <= idx;
                  out_hit   <= 1'b1;
               end
               if (last_bit) total <= total_sat;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_scan_controller.sv
// tb/tb_pattern_scan_controller.sv - self-checking bench for pattern_scan_controller
// A scripted detector stub matches on chosen bit indices; a second instance with TOT_W=4 checks saturation.
module tb_pattern_scan_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_ready;
   logic [1:0]  det_o;

   logic        in_ready, det_rst, det_i, out_valid, out_hit;
   logic [4:0]  out_count, out_first;
   logic [15:0] total;

   logic        s_in_ready, s_det_rst, s_det_i, s_out_valid, s_out_hit;
   logic [4:0]  s_out_count, s_out_first;
   logic [3:0]  s_total;

   always #5 clock = ~clock;

   pattern_scan_controller dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .det_rst(det_rst), .det_i(det_i), .det_o(det_o), .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_hit(out_hit), .out_first(out_first), .total(total)
   );

   pattern_scan_controller #(.WIDTH(16), .CNT_W(5), .TOT_W(4)) dut_sat (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .det_rst(s_det_rst), .det_i(s_det_i), .det_o(det_o), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_count(s_out_count), .out_hit(s_out_hit), .out_first(s_out_first), .total(s_total)
   );

   // Stub: match where cur_mask is set; outside SHIFT it drives the match code to prove it is ignored.
   logic [15:0] cur_mask = '0;
   logic [4:0]  stub_idx = '0;
   always @(posedge clock) stub_idx <= det_rst ? 5'd0 : stub_idx + 5'd1;
   assign det_o = det_rst ? 2'b10 :
                  (cur_mask[stub_idx[3:0]] ? 2'b10 : (stub_idx[0] ? 2'b11 : 2'b01));

   typedef struct {
      logic [4:0]  count;
      logic [4:0]  first;
      logic        hit;
      logic [15:0] tot;
      logic [3:0]  sat;
   } exp_t;

   typedef struct {
      logic [15:0] data;
      logic [15:0] mask;
      int          hold;
      logic [4:0]  count;
      logic [4:0]  first;
      logic        hit;
   } vec_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_miss = 0;
   int   m_total;
   int   m_sat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      m_total = 0;
      m_sat   = 0;
      sb.delete();
   endtask

   task automatic send(input logic [15:0] d, input logic [15:0] m, input int hold,
                       input logic [4:0] ec, input logic [4:0] ef, input logic eh);
      exp_t e;
      exp_t got;
      int   t = 0;
      cur_mask = m;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      m_total = (m_total + ec > 65535) ? 65535 : m_total + ec;
      m_sat   = (m_sat + ec > 15) ? 15 : m_sat + ec;
      e = '{count: ec, first: ef, hit: eh, tot: 16'(m_total), sat: 4'(m_sat)};
      sb.push_back(e);
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clock);
         chk("det_rst_shift", 32'(det_rst), 32'd0);
         chk("det_i_bit", 32'(det_i), 32'(d[15-k]));
      end
      @(negedge clock);
      chk("out_valid_latency", 32'(out_valid), 32'd1);
      chk("total_at_done", 32'(total), 32'(e.tot));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_data  = 16'hFFFF;
         chk("in_ready_in_done", 32'(in_ready), 32'd0);
         chk("count_stable", 32'(out_count), 32'(ec));
         chk("first_stable", 32'(out_first), 32'(ef));
         chk("valid_stable", 32'(out_valid), 32'd1);
         @(negedge clock);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         chk("out_valid", 32'(out_valid), 32'd1);
         chk("out_count", 32'(out_count), 32'(got.count));
         chk("out_first", 32'(out_first), 32'(got.first));
         chk("out_hit", 32'(out_hit), 32'(got.hit));
         chk("total", 32'(total), 32'(got.tot));
         chk("total_sat4", 32'(s_total), 32'(got.sat));
      end
      @(posedge clock);
      @(negedge clock);
      out_ready = 1'b0;
      chk("in_ready_after_hs", 32'(in_ready), 32'd1);
      chk("out_valid_after_hs", 32'(out_valid), 32'd0);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{data: 16'hA5C3, mask: 16'h0088, hold: 5, count: 5'd2,  first: 5'd3,  hit: 1'b1};
      vecs[1] = '{data: 16'h0000, mask: 16'h0001, hold: 0, count: 5'd1,  first: 5'd0,  hit: 1'b1};
      vecs[2] = '{data: 16'hFFFF, mask: 16'h0000, hold: 2, count: 5'd0,  first: 5'd0,  hit: 1'b0};
      vecs[3] = '{data: 16'h1234, mask: 16'h8000, hold: 0, count: 5'd1,  first: 5'd15, hit: 1'b1};
      vecs[4] = '{data: 16'hF0F0, mask: 16'hFFFF, hold: 1, count: 5'd16, first: 5'd0,  hit: 1'b1};
      vecs[5] = '{data: 16'h5555, mask: 16'h0402, hold: 0, count: 5'd2,  first: 5'd1,  hit: 1'b1};

      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;
      @(negedge clock);
      do_reset();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_det_rst", 32'(det_rst), 32'd1);
      chk("rst_det_i", 32'(det_i), 32'd0);
      chk("rst_total", 32'(total), 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);

      for (int v = 0; v < 6; v++)
         send(vecs[v].data, vecs[v].mask, vecs[v].hold, vecs[v].count, vecs[v].first, vecs[v].hit);

      // Reset during bit 8 of a word that has already matched twice.
      cur_mask = 16'h0088;
      in_valid = 1'b1;
      in_data  = 16'hA5C3;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (8) @(negedge clock);
      chk("midscan_det_rst", 32'(det_rst), 32'd0);
      chk("midscan_count", 32'(out_count), 32'd2);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      m_total = 0;
      m_sat   = 0;
      chk("midscan_idle", 32'(in_ready), 32'd1);
      chk("midscan_out_valid", 32'(out_valid), 32'd0);
      chk("midscan_total", 32'(total), 32'd0);
      chk("midscan_det_rst_idle", 32'(det_rst), 32'd1);
      repeat (20) @(negedge clock);
      chk("midscan_no_result", 32'(out_valid), 32'd0);
      chk("midscan_total_late", 32'(total), 32'd0);

      // Two full-match words: the 4-bit total pins at 15, the 16-bit one keeps counting.
      send(16'hFFFF, 16'hFFFF, 0, 5'd16, 5'd0, 1'b1);
      send(16'h0F0F, 16'hFFFF, 0, 5'd16, 5'd0, 1'b1);
      chk("sat_total_final", 32'(s_total), 32'd15);
      chk("wide_total_final", 32'(total), 32'd32);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
